// File: rtl/instr_fetch_unit_if.sv
// Bundles the instruction-fetch block's two data paths into one interface.
//   imem side   : imem_req/imem_addr out, imem_ready/imem_rvalid/imem_rdata in
//   execute side: redirect_valid/redirect_pc in
//   decode side : instr_valid/instr/instr_pc out, instr_ready in
//   status      : err_misaligned out
// master = the fetch unit, slave = its environment (memory, execute, decode).
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        err_misaligned;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, err_misaligned,
    input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, err_misaligned,
    output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time to
// instruction memory, buffers returned {pc, word} pairs in a small FIFO and
// presents them to decode under valid/ready. Execute redirects flush the
// buffer and drop any response still in flight.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - instr_fetch_unit_if.master (imem, redirect, decode, error flag)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic              clk,
  input logic              rst_n,
  instr_fetch_unit_if.master bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  logic [31:0]                  fetch_pc;
  logic [31:0]                  req_pc;
  logic                         outstanding;
  logic                         drop;
  logic                         err;
  entry_t [FIFO_DEPTH-1:0]      fifo_q;
  logic [PW-1:0]                rd_ptr;
  logic [PW-1:0]                wr_ptr;
  logic [PW:0]                  count;

  logic   fifo_valid;
  logic   accept;
  logic   rsp;
  logic   push;
  logic   pop;
  entry_t head;

  assign fifo_valid = (count != '0);
  assign head       = fifo_q[rd_ptr];

  // With at most one request in flight and issue blocked while it is, the
  // credit test reduces to count < depth: a response always has a free slot.
  assign bus.imem_req = rst_n && !bus.redirect_valid && !err && !outstanding &&
                        (count < DEPTH_C);
  assign bus.imem_addr      = fetch_pc;
  assign bus.err_misaligned = err;
  assign bus.instr_valid    = fifo_valid;
  assign bus.instr          = fifo_valid ? head.word : '0;
  assign bus.instr_pc       = fifo_valid ? head.pc   : '0;

  assign accept = bus.imem_req && bus.imem_ready;
  // A response with nothing outstanding (e.g. left over from before reset)
  // is ignored entirely.
  assign rsp    = bus.imem_rvalid && outstanding;
  assign push   = rsp && !drop && !bus.redirect_valid;
  assign pop    = fifo_valid && bus.instr_ready && !bus.redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      err         <= 1'b0;
      fifo_q      <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (bus.redirect_valid) begin
      // Redirect wins over everything: flush, retarget, and either swallow a
      // same-cycle response or mark the in-flight one to be dropped later.
      fetch_pc    <= bus.redirect_pc;
      err         <= |bus.redirect_pc[1:0];
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding && !bus.imem_rvalid;
      drop        <= outstanding && !bus.imem_rvalid;
    end else begin
      if (accept) begin
        outstanding <= 1'b1;
        req_pc      <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end else if (rsp) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end
      if (push) begin
        fifo_q[wr_ptr] <= entry_t'{pc: req_pc, word: bus.imem_rdata};
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Instance a uses RESET_PC=0 with a
// variable-latency memory model driven from tick(); instance b uses
// RESET_PC=0xFFFFFFF8 with a free-running 1-cycle memory to show PC wrap.
module tb_instr_fetch_unit;
  logic clk;
  logic rst_n;

  instr_fetch_unit_if bus_a();
  instr_fetch_unit_if bus_b();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // memory model state for instance a
  bit          m_pend = 0;
  int          m_cnt  = 0;
  logic [31:0] m_addr = '0;
  int          lat    = 1;
  bit          mem_rdy = 1;
  logic [31:0] acc_q[$];

  // observations from instance b
  logic [31:0] b_q[$];
  logic [31:0] b_iq[$];
  bit          b_pend = 0;
  logic [31:0] b_addr = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called at a negedge: drive memory inputs for the coming posedge, let it
  // pass, clear the redirect pulse, and return at the next negedge.
  task automatic tick();
    #1;
    if (m_pend && m_cnt == 0) begin
      bus_a.imem_rvalid = 1'b1;
      bus_a.imem_rdata  = m_addr;
      m_pend = 0;
    end else begin
      bus_a.imem_rvalid = 1'b0;
      bus_a.imem_rdata  = 32'hDEAD_BEEF;
      if (m_pend) m_cnt--;
    end
    bus_a.imem_ready = mem_rdy && !m_pend;
    #1;
    if (bus_a.imem_req && bus_a.imem_ready) begin
      m_pend = 1;
      m_cnt  = lat - 1;
      m_addr = bus_a.imem_addr;
      acc_q.push_back(bus_a.imem_addr);
    end
    @(posedge clk);
    #1 bus_a.redirect_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_pc    = pc;
    tick();
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (bus_a.instr_valid) break;
      tick();
    end
    chk(tag, bus_a.instr_valid, 1'b1);
  endtask

  // instance b: always-ready 1-cycle memory and decoder
  initial begin
    bus_b.imem_ready     = 1'b1;
    bus_b.imem_rvalid    = 1'b0;
    bus_b.imem_rdata     = '0;
    bus_b.redirect_valid = 1'b0;
    bus_b.redirect_pc    = '0;
    bus_b.instr_ready    = 1'b1;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus_b.instr_valid && b_q.size() < 3) begin
        b_q.push_back(bus_b.instr_pc);
        b_iq.push_back(bus_b.instr);
      end
      bus_b.imem_rvalid = b_pend;
      bus_b.imem_rdata  = b_addr;
      b_pend = 0;
      #1;
      if (bus_b.imem_req) begin
        b_pend = 1;
        b_addr = bus_b.imem_addr;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    int          n_pop;
    bit          any;

    rst_n = 1'b0;
    bus_a.imem_ready     = 1'b0;
    bus_a.imem_rvalid    = 1'b0;
    bus_a.imem_rdata     = '0;
    bus_a.redirect_valid = 1'b0;
    bus_a.redirect_pc    = '0;
    bus_a.instr_ready    = 1'b1;
    @(negedge clk);
    tick();
    tick();

    // reset state
    chk("rst_req",   bus_a.imem_req, 1'b0);
    chk("rst_valid", bus_a.instr_valid, 1'b0);
    chk("rst_instr", bus_a.instr, 32'h0);
    chk("rst_pc",    bus_a.instr_pc, 32'h0);
    chk("rst_err",   bus_a.err_misaligned, 1'b0);

    // streaming with 1-cycle memory: one word every two cycles
    rst_n = 1'b1;
    #1;
    chk("t1_req0",  bus_a.imem_req, 1'b1);
    chk("t1_addr0", bus_a.imem_addr, 32'h0);
    acc_q.delete();
    exp_pc = 32'h0;
    n_pop  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_a.instr_valid) begin
        chk("t1_pc",    bus_a.instr_pc, exp_pc);
        chk("t1_instr", bus_a.instr, exp_pc);
        exp_pc += 32'd4;
        n_pop++;
      end
    end
    chk("t1_npop", n_pop, 10);
    chk("t1_nacc", acc_q.size(), 10);
    chk("t1_acc1", acc_q[1], 32'h4);
    chk("t1_acc2", acc_q[2], 32'h8);

    // wrap from 0xFFFFFFF8
    chk("wrap_n",  b_q.size(), 3);
    chk("wrap_p0", b_q[0], 32'hFFFF_FFF8);
    chk("wrap_i0", b_iq[0], 32'hFFFF_FFF8);
    chk("wrap_p1", b_q[1], 32'hFFFF_FFFC);
    chk("wrap_p2", b_q[2], 32'h0000_0000);

    // decoder stall: two words buffered, fetch stops, then drains in order
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus_a.instr_ready = 1'b0;
    acc_q.delete();
    repeat (10) tick();
    chk("t2_valid", bus_a.instr_valid, 1'b1);
    chk("t2_pc0",   bus_a.instr_pc, 32'h0);
    chk("t2_req",   bus_a.imem_req, 1'b0);
    chk("t2_addr",  bus_a.imem_addr, 32'h8);
    chk("t2_nacc",  acc_q.size(), 2);
    bus_a.instr_ready = 1'b1;
    tick();
    chk("t2_pc1",   bus_a.instr_pc, 32'h4);
    tick();
    chk("t2_empty", bus_a.instr_valid, 1'b0);
    tick();
    chk("t2_pc2",   bus_a.instr_pc, 32'h8);

    // 3-cycle memory, redirect one cycle after 0x8 is accepted
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    lat   = 3;
    for (int i = 0; i < 40; i++) begin
      if (m_pend && m_addr == 32'h8) break;
      tick();
    end
    redirect(32'h100);
    chk("t3_valid", bus_a.instr_valid, 1'b0);
    chk("t3_addr",  bus_a.imem_addr, 32'h100);
    chk("t3_req",   bus_a.imem_req, 1'b0);
    wait_valid("t3_wait");
    chk("t3_pc",    bus_a.instr_pc, 32'h100);
    chk("t3_instr", bus_a.instr, 32'h100);

    // redirect in the same cycle as the response
    for (int i = 0; i < 10; i++) begin
      if (m_pend && m_cnt == 0) break;
      tick();
    end
    redirect(32'h200);
    chk("t4_req",   bus_a.imem_req, 1'b1);
    chk("t4_addr",  bus_a.imem_addr, 32'h200);
    chk("t4_valid", bus_a.instr_valid, 1'b0);
    wait_valid("t4_wait");
    chk("t4_pc",    bus_a.instr_pc, 32'h200);
    chk("t4_instr", bus_a.instr, 32'h200);

    // redirect during an imem_ready=0 stall with a buffered word
    bus_a.instr_ready = 1'b0;
    mem_rdy = 0;
    tick();
    chk("t5_hold_req",  bus_a.imem_req, 1'b1);
    chk("t5_hold_addr", bus_a.imem_addr, 32'h204);
    tick();
    chk("t5_hold_addr2", bus_a.imem_addr, 32'h204);
    chk("t5_hold_pc",    bus_a.instr_pc, 32'h200);
    redirect(32'h300);
    chk("t5_flush", bus_a.instr_valid, 1'b0);
    chk("t5_addr",  bus_a.imem_addr, 32'h300);
    chk("t5_req",   bus_a.imem_req, 1'b1);
    mem_rdy = 1;
    bus_a.instr_ready = 1'b1;
    wait_valid("t5_wait");
    chk("t5_pc", bus_a.instr_pc, 32'h300);

    // misaligned redirect locks fetch until an aligned redirect
    redirect(32'h102);
    chk("t6_err",   bus_a.err_misaligned, 1'b1);
    chk("t6_valid", bus_a.instr_valid, 1'b0);
    chk("t6_req",   bus_a.imem_req, 1'b0);
    chk("t6_addr",  bus_a.imem_addr, 32'h102);
    any = 0;
    repeat (5) begin
      tick();
      any |= bus_a.imem_req | bus_a.instr_valid;
    end
    chk("t6_quiet", any, 1'b0);
    redirect(32'h200);
    chk("t6_clr",  bus_a.err_misaligned, 1'b0);
    chk("t6_req2", bus_a.imem_req, 1'b1);
    chk("t6_addr2", bus_a.imem_addr, 32'h200);
    wait_valid("t6_wait");
    chk("t6_pc", bus_a.instr_pc, 32'h200);

    // reset mid-fetch; the late response must be ignored
    tick();
    rst_n = 1'b0;
    tick();
    chk("t7_req",   bus_a.imem_req, 1'b0);
    chk("t7_valid", bus_a.instr_valid, 1'b0);
    chk("t7_instr", bus_a.instr, 32'h0);
    chk("t7_pc",    bus_a.instr_pc, 32'h0);
    chk("t7_addr",  bus_a.imem_addr, 32'h0);
    rst_n = 1'b1;
    wait_valid("t7_wait");
    chk("t7_pc2",    bus_a.instr_pc, 32'h0);
    chk("t7_instr2", bus_a.instr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the instruction decoder.
- Owns the program counter and issues word fetches to instruction memory over a request/response handshake.
- Buffers returned words with their PC in a small FIFO, and presents one instruction per cycle to decode under valid/ready.
- Handles branch/jump redirects from execute, including flushing buffered words and dropping an in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  32  word-aligned fetch address
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  fetched instruction word
redirect_valid  input  1  execute requests PC change (taken branch/jal/jalr)
redirect_pc  input  32  new fetch target
instr_valid  output  1  instr/instr_pc valid to decoder
instr  output  32  instruction word to decoder
instr_pc  output  32  PC of instr
instr_ready  input  1  decoder consumes instr this cycle
err_misaligned  output  1  sticky: last redirect target not 4-byte aligned

Behaviour:
- Reset (rst_n=0 at posedge): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0, err_misaligned=0. Outputs imem_req=0, instr_valid=0, instr=0, instr_pc=0.
- Reset mid-operation discards everything. An imem_rvalid seen with outstanding=0 is ignored.
- imem_addr = fetch_pc always.
- Issue condition: imem_req=1 iff rst_n && !redirect_valid && !err_misaligned && outstanding==0 && (fifo_count + outstanding) < FIFO_DEPTH.
- Credit rule: FIFO never overflows; no full-push case exists.
- Request accepted when imem_req && imem_ready. Next cycle: outstanding=1, fetch_pc=fetch_pc+4.
- PC arithmetic is mod 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- While imem_req=1 and imem_ready=0, imem_addr is held stable.
- Only one request is outstanding at a time.
- Memory contract: imem_rvalid arrives >=1 cycle after acceptance, with variable latency.
- Response (imem_rvalid && outstanding):
  - Clear outstanding.
  - If drop=1: discard data, clear drop.
  - Else push {pc_of_req, imem_rdata}. pc_of_req is latched at acceptance.
- A new request may issue in the cycle after the response (credit permitting). Back-to-back throughput is 1 word per 2 cycles minimum with 1-cycle memory.
- Decode side:
  - instr_valid = FIFO non-empty. instr/instr_pc = FIFO head, registered.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle keeps the count.
  - A push into an empty FIFO becomes visible the next cycle (1-cycle response-to-decode latency).
- Redirect (highest priority, single-cycle pulse):
  - FIFO flushed: instr_valid=0 next cycle. A same-cycle pop and push are both discarded.
  - fetch_pc=redirect_pc.
  - imem_req forced 0 in the redirect cycle.
  - If outstanding=1 and no imem_rvalid this cycle: set drop=1.
  - If imem_rvalid is in the same cycle: discard it, outstanding=0, drop=0.
  - A request issued while drop=1 is impossible (outstanding blocks issue).
- Misaligned redirect (redirect_pc[1:0]!=0): err_misaligned=1 next cycle, fetch_pc=redirect_pc, no further requests. Cleared by the next redirect with aligned target. Flush and drop rules still apply.
- Decoder stall (instr_ready=0): FIFO fills to FIFO_DEPTH, then imem_req=0 until a pop frees credit.

Test Plan:
- Reset release, 1-cycle memory returning {addr}, instr_ready=1 -> imem_addr 0x0,0x4,0x8...; instr/instr_pc pairs (0x0,0x0),(0x4,0x4) in order, no gaps beyond 1-per-2-cycles.
- instr_ready=0 for 10 cycles -> exactly 2 words buffered (PC 0x0,0x4), imem_req=0. Then ready=1 -> both popped in order, fetch resumes at 0x8.
- Memory latency 3 cycles, redirect_pc=0x100 one cycle after acceptance of 0x8 -> 0x8 data dropped, FIFO flushed. Next instr_pc=0x100, no stale word appears.
- Redirect in the same cycle as imem_rvalid, and redirect during imem_ready=0 stall -> response discarded, next imem_addr equals redirect_pc, outstanding logic recovers with no hang.
- RESET_PC=32'hFFFF_FFF8 -> fetch order 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- redirect_pc=0x102 -> err_misaligned=1, imem_req stays 0, instr_valid=0. Then redirect_pc=0x200 -> err cleared, fetch 0x200. rst_n=0 mid-fetch -> all outputs 0, late imem_rvalid ignored.
